// File: rtl/bcd_xs3_if.sv
// Start/busy/done handshake and data bundle for the BCD to excess-3 sequencer.
// The master drives the operand and control; the slave is the converter.
interface bcd_xs3_if #(
  parameter int NDIGITS = 4
);
  logic                   start;
  logic                   en;
  logic [4*NDIGITS-1:0]   bcd_in;
  logic                   busy;
  logic                   done;
  logic [4*NDIGITS-1:0]   xs3_out;
  logic [NDIGITS-1:0]     err_mask;

  modport master (
    output start, en, bcd_in,
    input  busy, done, xs3_out, err_mask
  );

  modport slave (
    input  start, en, bcd_in,
    output busy, done, xs3_out, err_mask
  );
endinterface

// File: rtl/bcd_xs3_seq.sv
// Multi-digit BCD to excess-3 sequencer sharing one 4-bit converter.
// Digits are converted LSD first, one per enabled cycle in CONV.
module bcd_xs3_seq #(
  parameter int NDIGITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  bcd_xs3_if.slave   bus
);
  localparam int W  = 4 * NDIGITS;
  localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [W-1:0]    op_q;
  logic [W-1:0]    xs3_q;
  logic [NDIGITS-1:0] err_q;
  logic [CW-1:0]   cnt;
  logic [3:0]      dig;
  logic [3:0]      cvt;
  logic            bad;
  logic            last;
  logic            step;
  logic            busy_c;
  logic            done_c;

  // Gate-level equations: W=A|BC|BD, X=B'C|B'D|BC'D', Y=(C^D)', Z=D'
  function automatic logic [3:0] to_xs3(input logic [3:0] d);
    logic a, b, c, e;
    a = d[3];
    b = d[2];
    c = d[1];
    e = d[0];
    return {a | (b & c) | (b & e),
            (~b & c) | (~b & e) | (b & ~c & ~e),
            ~(c ^ e),
            ~e};
  endfunction

  assign dig  = op_q[{cnt, 2'b00} +: 4];
  assign bad  = dig > 4'd9;
  assign cvt  = bad ? 4'b0000 : to_xs3(dig);
  assign last = cnt == CW'(NDIGITS - 1);
  assign step = (state == CONV) && bus.en;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = CONV;
      CONV:    if (bus.en && last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_c = state != IDLE;
    done_c = state == DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      xs3_q <= '0;
      err_q <= '0;
      cnt   <= '0;
    end else if (state == IDLE && bus.start) begin
      op_q  <= bus.bcd_in;
      xs3_q <= '0;
      err_q <= '0;
      cnt   <= '0;
    end else if (step) begin
      xs3_q[{cnt, 2'b00} +: 4] <= cvt;
      err_q[cnt]               <= bad;
      if (!last) cnt <= cnt + 1'b1;
    end
  end

  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.xs3_out  = xs3_q;
  assign bus.err_mask = err_q;
endmodule

// File: tb/tb_bcd_xs3_seq.sv
// Scoreboard bench for bcd_xs3_seq: stimulus queues expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_bcd_xs3_seq;
  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bcd_xs3_if #(.NDIGITS(ND)) ifc ();

  bcd_xs3_seq #(.NDIGITS(ND)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct packed {
    logic [15:0] x;
    logic [3:0]  e;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ifc.done === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(ifc.done), 32'd0);
      end else begin
        e = sb.pop_front();
        check("xs3_out", 32'(ifc.xs3_out), 32'(e.x));
        check("err_mask", 32'(ifc.err_mask), 32'(e.e));
        check("busy_in_done", 32'(ifc.busy), 32'd1);
      end
    end
  end

  task automatic wait_done(output int n);
    bit seen;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ifc.done === 1'b1) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 32'(ifc.done), 32'd1);
  endtask

  task automatic issue(logic [15:0] b);
    ifc.bcd_in = b;
    ifc.start  = 1'b1;
    @(posedge clk);
    #1 ifc.start = 1'b0;
  endtask

  task automatic run(string nm, logic [15:0] b,
                     logic [15:0] ex, logic [3:0] ee);
    int n;
    sb.push_back('{x: ex, e: ee});
    issue(b);
    wait_done(n);
    check({nm, "_latency"}, 32'(n), 32'd4);
    @(posedge clk);
    #1;
    check({nm, "_idle_busy"}, 32'(ifc.busy), 32'd0);
    check({nm, "_hold"}, 32'(ifc.xs3_out), 32'(ex));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int pre;
    logic [15:0] v;
    logic [15:0] w;

    ifc.start  = 1'b0;
    ifc.en     = 1'b1;
    ifc.bcd_in = '0;
    rst        = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_done", 32'(ifc.done), 32'd0);
    check("rst_xs3", 32'(ifc.xs3_out), 32'd0);
    check("rst_err", 32'(ifc.err_mask), 32'd0);
    rst = 1'b0;

    run("basic", 16'h1234, 16'h4567, 4'b0000);
    run("bound", 16'h9050, 16'hC383, 4'b0000);
    for (int d = 0; d < 10; d++) begin
      v = 16'(d) * 16'h1111;
      w = 16'(d + 3) * 16'h1111;
      run("sweep", v, w, 4'b0000);
    end
    run("inval", 16'h12A4, 16'h4507, 4'b0010);
    run("allf", 16'hFFFF, 16'h0000, 4'b1111);

    // stall three cycles after digits 0 and 1 have converted
    sb.push_back('{x: 16'h4567, e: 4'b0000});
    issue(16'h1234);
    @(posedge clk);
    @(posedge clk);
    #1 ifc.en = 1'b0;
    check("stall_pre", 32'(ifc.xs3_out), 32'h0067);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_hold", 32'(ifc.xs3_out), 32'h0067);
      check("stall_busy", 32'(ifc.busy), 32'd1);
    end
    ifc.en = 1'b1;
    pre = 5;
    wait_done(n);
    check("stall_latency", 32'(pre + n), 32'd7);
    @(posedge clk);
    #1;

    // start held high, operand changed mid-conversion
    sb.push_back('{x: 16'h4567, e: 4'b0000});
    sb.push_back('{x: 16'h89AB, e: 4'b0000});
    ifc.bcd_in = 16'h1234;
    ifc.start  = 1'b1;
    @(posedge clk);
    #1 ifc.bcd_in = 16'h5678;
    wait_done(n);
    check("proto_lat1", 32'(n), 32'd4);
    @(posedge clk);
    #1;
    check("proto_done_ign", 32'(ifc.busy), 32'd0);
    wait_done(n);
    check("proto_lat2", 32'(n), 32'd5);
    ifc.start = 1'b0;
    @(posedge clk);
    #1;
    check("proto_idle", 32'(ifc.busy), 32'd0);

    // reset while cnt == 2
    issue(16'h1234);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid_pre_xs3", 32'(ifc.xs3_out), 32'h0067);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_busy", 32'(ifc.busy), 32'd0);
    check("mid_done", 32'(ifc.done), 32'd0);
    check("mid_xs3", 32'(ifc.xs3_out), 32'd0);
    check("mid_err", 32'(ifc.err_mask), 32'd0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mid_stay_idle", 32'(ifc.busy), 32'd0);
    run("post_rst", 16'h0876, 16'h3BA9, 4'b0000);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
